// File: rtl/cpu_pkg.sv
// Shared fetch-path definitions: fetch FSM state encodings, instruction width, PC step.
// Pure declarations, no timing of its own.
// No flow control here; consumers own their handshakes.
package cpu_pkg;

    localparam int INST_W = 32;
    localparam int PC_INC = 4;

    // Fetch sequencer state encodings (kept as plain 2-bit constants).
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t IDLE  = 2'd0;
    localparam fetch_state_t FETCH = 2'd1;
    localparam fetch_state_t HOLD  = 2'd2;
    localparam fetch_state_t ERR   = 2'd3;

    // A fetch address is legal only on a 32-bit word boundary.
    function automatic logic word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/ack bus plus the fetched-instruction hand-off to decode.
// Latency is set by whoever drives it; the interface adds none.
// Memory side uses req/ack, decode side uses valid/ready.
interface pc_fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              imem_req_o;
    logic [ADDR_W-1:0] imem_addr_o;
    logic              imem_ack_i;
    logic [INST_W-1:0] imem_rdata_i;
    logic [INST_W-1:0] inst_o;
    logic              inst_valid_o;
    logic              inst_ready_i;

    // Fetch unit side.
    modport master (
        output imem_req_o, imem_addr_o, inst_o, inst_valid_o,
        input  imem_ack_i, imem_rdata_i, inst_ready_i
    );

    // Memory / decode side.
    modport slave (
        input  imem_req_o, imem_addr_o, inst_o, inst_valid_o,
        output imem_ack_i, imem_rdata_i, inst_ready_i
    );
endinterface

// File: rtl/pc_adder.sv
// ADDR_W-bit PC incrementer feeding the sequential-PC leg of the next-PC mux.
// Purely combinational, wraps modulo 2^ADDR_W.
// No flow control.
module pc_adder
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_i,
    output logic [ADDR_W-1:0] sum_o
);

    assign sum_o = pc_i + ADDR_W'(PC_INC);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer (IDLE -> FETCH -> HOLD -> FETCH ..., ERR is terminal).
// Latency: ack in the first FETCH cycle gives inst_valid_o on the next cycle; one instruction per 2 cycles max.
// Backpressure: holds inst_o until decode accepts with stall_i low; FETCH waits on imem_ack_i
// (bounded by MAX_WAIT only when FETCH_TIMEOUT_EN is defined).
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] next_pc_i,
    input  logic              stall_i,
    pc_fetch_unit_if.master   bus,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              fetch_err_o
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc_q;
    logic [INST_W-1:0] inst_q;
    logic              accept;
    logic              timeout;

    if (MAX_WAIT < 1) begin : g_max_wait_chk
        $error("MAX_WAIT must be at least 1");
    end

    // stall_i overrides inst_ready_i: a stalled cycle never consumes the held instruction.
    assign accept = (state == HOLD) && bus.inst_ready_i && !stall_i;

`ifdef FETCH_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_cnt;

    // Count ack-less FETCH cycles; the counter sits at zero outside FETCH so each fetch starts fresh.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
        end else if (state != FETCH) begin
            wait_cnt <= '0;
        end else if (!bus.imem_ack_i) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Fires on the MAX_WAIT-th FETCH cycle only if no ack arrives in that same cycle.
    assign timeout = (state == FETCH) && !bus.imem_ack_i
                     && (wait_cnt == WAIT_W'(MAX_WAIT - 1));
`else
    assign timeout = 1'b0;
`endif

    // Sequencer: ack is only looked at in FETCH, so stray or post-reset acks are harmless.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            pc_q   <= RESET_PC;
            inst_q <= '0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (bus.imem_ack_i) begin
                        inst_q <= bus.imem_rdata_i;
                        state  <= HOLD;
                    end else if (timeout) begin
                        state <= ERR;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        if (word_aligned(next_pc_i[1:0])) begin
                            pc_q  <= next_pc_i;
                            state <= FETCH;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                ERR:     state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

    // Every handshake output is a pure decode of registered state, so reset clears them without a clock.
    assign bus.imem_req_o   = (state == FETCH);
    assign bus.imem_addr_o  = pc_q;
    assign bus.inst_o       = inst_q;
    assign bus.inst_valid_o = (state == HOLD);
    assign fetch_err_o      = (state == ERR);
    assign pc_o             = pc_q;

    pc_adder #(.ADDR_W(ADDR_W)) u_pc_adder (
        .pc_i  (pc_q),
        .sum_o (pc_plus4_o)
    );

endmodule
